// File: rtl/afe_sequence_engine_if.sv
// Bundle of control, ROM and serial-shifter signals between the AFE sequence
// engine (master) and its environment (slave).
interface afe_sequence_engine_if #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 8,
    parameter int OP_W   = 4
);
    logic                   enable;
    logic                   abort;
    logic                   serial_ready;
    logic [OP_W+DATA_W-1:0] rom_data;
    logic [ADDR_W-1:0]      rom_address;
    logic [DATA_W-1:0]      afe_command;
    logic                   start_transaction;
    logic                   busy;
    logic                   done;
    logic                   error;

    modport master (
        input  enable, abort, serial_ready, rom_data,
        output rom_address, afe_command, start_transaction, busy, done, error
    );

    modport slave (
        output enable, abort, serial_ready, rom_data,
        input  rom_address, afe_command, start_transaction, busy, done, error
    );
endinterface

// File: rtl/afe_sequence_engine.sv
// ROM-driven sequencer that walks opcode+payload words and feeds the AFE serial
// shifter; supports SEND, timed WAIT, JUMP and END with error reporting.
module afe_sequence_engine #(
    parameter int DATA_W      = 20,
    parameter int ADDR_W      = 8,
    parameter int OP_W        = 4,
    parameter int ROM_LATENCY = 1,
    parameter int DELAY_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    afe_sequence_engine_if.master bus
);
    localparam int FC_W = $clog2(ROM_LATENCY + 1) + 1;

    localparam logic [OP_W-1:0] OP_END  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SEND = OP_W'(1);
    localparam logic [OP_W-1:0] OP_WAIT = OP_W'(2);
    localparam logic [OP_W-1:0] OP_JUMP = OP_W'(3);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_WAIT_SER, S_HOLD,
        S_DELAY, S_NEXT, S_DONE, S_ERROR
    } state_t;

    state_t              state, state_nxt;
    logic [OP_W-1:0]     opcode, opcode_nxt;
    logic [DATA_W-1:0]   payload, payload_nxt;
    logic [FC_W-1:0]     fetch_cnt, fetch_cnt_nxt;
    logic [DELAY_W-1:0]  delay_cnt, delay_cnt_nxt;
    logic [ADDR_W-1:0]   rom_address, rom_address_nxt;
    logic [DATA_W-1:0]   afe_command, afe_command_nxt;
    logic                start_q, start_nxt;
    logic                busy_q, busy_nxt;
    logic                done_q, done_nxt;
    logic                error_q, error_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            opcode      <= '0;
            payload     <= '0;
            fetch_cnt   <= '0;
            delay_cnt   <= '0;
            rom_address <= '0;
            afe_command <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state       <= state_nxt;
            opcode      <= opcode_nxt;
            payload     <= payload_nxt;
            fetch_cnt   <= fetch_cnt_nxt;
            delay_cnt   <= delay_cnt_nxt;
            rom_address <= rom_address_nxt;
            afe_command <= afe_command_nxt;
            start_q     <= start_nxt;
            busy_q      <= busy_nxt;
            done_q      <= done_nxt;
            error_q     <= error_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        opcode_nxt      = opcode;
        payload_nxt     = payload;
        fetch_cnt_nxt   = '0;  // restarts on every FETCH entry
        delay_cnt_nxt   = delay_cnt;
        rom_address_nxt = rom_address;
        afe_command_nxt = afe_command;
        start_nxt       = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.enable) begin
                    rom_address_nxt = '0;
                    state_nxt       = S_FETCH;
                end
            end
            S_FETCH: begin
                // one cycle for the address register, ROM_LATENCY for the ROM
                if (fetch_cnt == FC_W'(ROM_LATENCY)) begin
                    opcode_nxt  = bus.rom_data[OP_W+DATA_W-1:DATA_W];
                    payload_nxt = bus.rom_data[DATA_W-1:0];
                    state_nxt   = S_DECODE;
                end else begin
                    fetch_cnt_nxt = fetch_cnt + FC_W'(1);
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_END:  state_nxt = S_DONE;
                    OP_SEND: state_nxt = S_WAIT_SER;
                    OP_WAIT: begin
                        if (payload[DELAY_W-1:0] == '0) begin
                            state_nxt = S_NEXT;
                        end else begin
                            delay_cnt_nxt = payload[DELAY_W-1:0];
                            state_nxt     = S_DELAY;
                        end
                    end
                    OP_JUMP: begin
                        rom_address_nxt = payload[ADDR_W-1:0];
                        state_nxt       = S_FETCH;
                    end
                    default: state_nxt = S_ERROR;
                endcase
            end
            S_WAIT_SER: begin
                if (bus.serial_ready) begin
                    afe_command_nxt = payload;
                    start_nxt       = 1'b1;
                    state_nxt       = S_HOLD;
                end
            end
            S_HOLD:  state_nxt = S_NEXT;
            S_DELAY: begin
                delay_cnt_nxt = delay_cnt - DELAY_W'(1);
                if (delay_cnt == DELAY_W'(1)) state_nxt = S_NEXT;
            end
            S_NEXT: begin
                // no wrap: running off the end of the ROM is an error
                if (&rom_address) begin
                    state_nxt = S_ERROR;
                end else begin
                    rom_address_nxt = rom_address + ADDR_W'(1);
                    state_nxt       = S_FETCH;
                end
            end
            S_DONE, S_ERROR: begin
                if (!bus.enable) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (bus.abort) begin
            state_nxt       = S_IDLE;
            start_nxt       = 1'b0;
            afe_command_nxt = afe_command;
            fetch_cnt_nxt   = '0;
            delay_cnt_nxt   = '0;
        end

        busy_nxt  = !(state_nxt inside {S_IDLE, S_DONE, S_ERROR});
        done_nxt  = (state_nxt inside {S_DONE, S_ERROR});
        error_nxt = (state_nxt == S_ERROR);
    end

    assign bus.rom_address       = rom_address;
    assign bus.afe_command       = afe_command;
    assign bus.start_transaction = start_q;
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
    assign bus.error             = error_q;
endmodule
